reciprocal_prenorm: RTL
=======================

# reciprocal_prenorm

Sequential range-reduction stage that sits directly upstream of the reciprocal CORDIC datapath. It takes a signed fixed-point operand with a valid/ready handshake and strips the sign. It then shifts the magnitude one bit per cycle until its value lies in [1.0, 2.0), where linear-mode vectoring converges. It emits the normalized magnitude, the shift count and the sign flag, which the downstream post-scaling stage uses to rebuild 1/x = sign · (1/x_norm) · 2^-shift.

## Interface
- FLOAT_SIZE, 24, fractional bits of the fixed-point format.
- INT_SIZE, 8, integer bits including sign; W = INT_SIZE + FLOAT_SIZE.
- SHW, $clog2(W)+1, width of the signed shift-count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- x  input  W  signed two's-complement operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- x_norm  output  W  unsigned magnitude in [1.0, 2.0), same Q format as x.
- shift  output  SHW  signed; |x| = x_norm · 2^shift.
- neg  output  1  operand was negative.
- div_zero  output  1  operand was zero.

## Operation
- States: IDLE, NORM, ROUND (only with the macro), OUT.
- IDLE: in_ready=1. On in_valid & in_ready:
  - capture mag = |x| as W-bit unsigned (-2^(W-1) maps to 2^(W-1) without overflow);
  - capture neg = x[W-1];
  - clear shift and guard;
  - go to NORM.
- NORM evaluates one rule per cycle, in priority order:
  1. mag == 0: div_zero=1, x_norm=0, shift=0, go to OUT.
  2. mag[W-1:FLOAT_SIZE+1] != 0: mag >>= 1, guard = bit shifted out, shift += 1.
  3. mag[FLOAT_SIZE] == 0: mag <<= 1, shift -= 1.
  4. Otherwise go to OUT, or to ROUND when rounding is compiled in.
- Shift range is -FLOAT_SIZE .. INT_SIZE-1; no saturation is needed.
- Left shifts never lose bits. Without rounding, right shifts truncate.
- ROUND: if guard=1, mag += 1.
  - If the increment carries to 2.0 (bit FLOAT_SIZE+1 set), force x_norm = 1.0 and shift += 1 in the same cycle.
  - Then go to OUT.
- OUT: out_valid=1. x_norm, shift, neg and div_zero are held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
  - in_ready returns the following cycle; there is no same-cycle turnaround.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored.

## Timing
- Reset (rst=0, asynchronous): state=IDLE.
  - in_ready=1 after release.
  - out_valid=0, x_norm=0, shift=0, neg=0, div_zero=0; guard cleared.
- Latency from the accept edge to the first out_valid cycle is 1 + |s| + 1 cycles, where s is the final shift.
  - Zero operand: 2 cycles.
  - Add 1 cycle when PRENORM_ROUND_EN is defined. This applies to all operands, including zero.
- Throughput is one operand per (latency + 1) cycles, given out_ready=1.
- Reset asserted mid-NORM or mid-OUT aborts the operation. No stale out_valid may appear after release.
- Outputs are registered; there is no combinational path from in_* to out_*.

## Configuration
- PRENORM_ROUND_EN defined:
  - the ROUND state is present;
  - right-shift results are rounded half-up on the last shifted-out bit;
  - carry into 2.0 renormalizes as described in Operation.
- PRENORM_ROUND_EN undefined:
  - no ROUND state and no guard logic;
  - right shifts truncate;
  - latency is one cycle shorter.

## Test plan
- x=0x01000000 (1.0), out_ready=1 -> x_norm=0x01000000, shift=0, neg=0, out_valid 2 cycles after accept (3 with rounding).
- x=0x04000000 (4.0) -> x_norm=0x01000000, shift=+2, out_valid 4 cycles after accept. Then x=0x00400000 (0.25) -> x_norm=0x01000000, shift=-2.
- x=0xFD000000 (-3.0) -> x_norm=0x01800000, shift=+1, neg=1. Then x=0x80000000 (-128.0) -> x_norm=0x01000000, shift=+7, neg=1.
- x=0 -> div_zero=1, x_norm=0, shift=0, out_valid 2 cycles after accept. The next operand clears div_zero.
- x=0x03000001:
  - with PRENORM_ROUND_EN -> x_norm=0x01800001, shift=+1;
  - without -> x_norm=0x01800000.
  - x=0x03FFFFFF with PRENORM_ROUND_EN -> x_norm=0x01000000, shift=+2.
- Hold out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0. Pulse rst low mid-NORM -> out_valid=0 and in_ready=1 after release.

Source files
------------

// File: rtl/reciprocal_prenorm.sv
// reciprocal_prenorm: strips the sign and walks |x| into [1.0, 2.0) one bit per cycle.
// Define PRENORM_ROUND_EN to add a ROUND cycle that rounds right-shift results half-up.
module reciprocal_prenorm #(
    parameter int FLOAT_SIZE = 24,
    parameter int INT_SIZE   = 8,
    parameter int W          = INT_SIZE + FLOAT_SIZE,
    parameter int SHW        = $clog2(W) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          x_norm,
    output logic signed [SHW-1:0] shift,
    output logic                  neg,
    output logic                  div_zero
);

    localparam logic [W-1:0] LSB = W'(1);
    localparam logic [W-1:0] ONE = LSB << FLOAT_SIZE;
    localparam logic signed [SHW-1:0] S_ONE = SHW'(1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
`ifdef PRENORM_ROUND_EN
        ROUND,
`endif
        OUT
    } state_e;

    state_e                state_q, state_d;
    logic [W-1:0]          mag_q, mag_d;
    logic signed [SHW-1:0] shift_q, shift_d;
    logic                  neg_q, neg_d;
    logic                  dz_q, dz_d;
    logic                  ov_q, ov_d;
    logic                  ir_q, ir_d;
    logic [W-1:0]          x_u;
`ifdef PRENORM_ROUND_EN
    logic                  guard_q, guard_d;
    logic [W-1:0]          inc;
`endif

    assign x_u = x;

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        shift_d = shift_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        ir_d    = ir_q;
`ifdef PRENORM_ROUND_EN
        guard_d = guard_q;
        inc     = mag_q + LSB;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Two's-complement negate keeps -2^(W-1) as 2^(W-1) unsigned
                    mag_d   = x_u[W-1] ? (~x_u + LSB) : x_u;
                    neg_d   = x_u[W-1];
                    shift_d = '0;
                    dz_d    = 1'b0;
                    ir_d    = 1'b0;
`ifdef PRENORM_ROUND_EN
                    guard_d = 1'b0;
`endif
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == '0) begin
                    dz_d    = 1'b1;
                    shift_d = '0;
`ifdef PRENORM_ROUND_EN
                    state_d = ROUND;
`else
                    state_d = OUT;
                    ov_d    = 1'b1;
`endif
                end else if (|mag_q[W-1:FLOAT_SIZE+1]) begin
                    mag_d   = mag_q >> 1;
                    shift_d = shift_q + S_ONE;
`ifdef PRENORM_ROUND_EN
                    guard_d = mag_q[0];
`endif
                end else if (!mag_q[FLOAT_SIZE]) begin
                    mag_d   = mag_q << 1;
                    shift_d = shift_q - S_ONE;
                end else begin
`ifdef PRENORM_ROUND_EN
                    state_d = ROUND;
`else
                    state_d = OUT;
                    ov_d    = 1'b1;
`endif
                end
            end
`ifdef PRENORM_ROUND_EN
            ROUND: begin
                if (guard_q) begin
                    // A carry into 2.0 only happens from all-ones, so result is exactly 1.0
                    if (inc[FLOAT_SIZE+1]) begin
                        mag_d   = ONE;
                        shift_d = shift_q + S_ONE;
                    end else begin
                        mag_d = inc;
                    end
                end
                state_d = OUT;
                ov_d    = 1'b1;
            end
`endif
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                    ir_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ov_d    = 1'b0;
                ir_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            shift_q <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            ir_q    <= 1'b1;
`ifdef PRENORM_ROUND_EN
            guard_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            shift_q <= shift_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            ir_q    <= ir_d;
`ifdef PRENORM_ROUND_EN
            guard_q <= guard_d;
`endif
        end
    end

    assign in_ready  = ir_q;
    assign out_valid = ov_q;
    assign x_norm    = mag_q;
    assign shift     = shift_q;
    assign neg       = neg_q;
    assign div_zero  = dz_q;

endmodule
